seq_event_monitor: RTL and testbench
====================================

SEQ_EVENT_MONITOR -- requirements
Module: seq_event_monitor

Interface
REQ-001 SHALL have parameter CW, default 8, giving the width of both event counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port en, input, 1, monitor enable.
REQ-005 SHALL have port clr, input, 1, synchronous clear of counters and error state.
REQ-006 SHALL have port mealy_in, input, 1, the output of the Mealy 10010 detector (asserts in the cycle the final 0 is present).
REQ-007 SHALL have port moore_in, input, 1, the output of the Moore 10010 detector (asserts one cycle after the Mealy output).
REQ-008 SHALL have port match_pulse, output, 1, registered one-cycle pulse per paired detection.
REQ-009 SHALL have port det_count, output, CW, the number of paired detections.
REQ-010 SHALL have port err_count, output, CW, the number of pairing errors.
REQ-011 SHALL have port err_flag, output, 1, sticky error indicator.
REQ-012 SHALL have port err_code, output, 2, the first error cause: 00 none, 01 missed Moore, 10 orphan Moore.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no Mealy event pending) and PEND (Mealy seen in the previous cycle, Moore expected in this cycle).
REQ-014 In IDLE with en=1, mealy_in=1 SHALL move the FSM to PEND.
REQ-015 In IDLE with en=1, moore_in=1 SHALL be an orphan-Moore error; this applies whether or not mealy_in is also 1, and next state is PEND if mealy_in=1, else IDLE.
REQ-016 In PEND with en=1 and moore_in=1, the monitor SHALL:
  - increment det_count;
  - set match_pulse=1 in the following cycle;
  - go to PEND if mealy_in=1, else to IDLE.
REQ-017 In PEND with en=1 and moore_in=0, the monitor SHALL:
  - flag a missed-Moore error;
  - go to PEND if mealy_in=1, else to IDLE.
REQ-018 Each error SHALL increment err_count by 1 and set err_flag=1.
REQ-019 err_code SHALL record the cause of the first error since reset or clr, and SHALL NOT change on later errors.
REQ-020 At most one error and one detection SHALL be counted per cycle.
REQ-021 det_count and err_count SHALL saturate at 2^CW-1 and never wrap.
REQ-022 All outputs SHALL be registered and SHALL reflect a given cycle's inputs after that cycle's rising edge (latency 1).
REQ-023 match_pulse SHALL be 0 in every cycle not directly following a pairing.
REQ-024 With en=0, the monitor SHALL:
  - force the FSM to IDLE and drop any pending event silently;
  - hold det_count, err_count, err_flag and err_code;
  - drive match_pulse to 0.
REQ-025 clr=1 SHALL zero det_count, err_count, err_flag, err_code and match_pulse, and force IDLE; clr overrides en.
REQ-026 rst SHALL take priority over clr and en.

Reset
REQ-027 On a rising edge with rst=1, the block SHALL set:
  - FSM to IDLE;
  - match_pulse=0, det_count=0, err_count=0, err_flag=0, err_code=00.
REQ-028 While rst=1, the mealy_in and moore_in inputs SHALL be ignored.
REQ-029 rst asserted mid-operation, including while in PEND, SHALL discard the pending event without counting an error.

Verification
REQ-030 Reset, en=1, mealy_in=1 for cycle N, then moore_in=1 for cycle N+1 -> match_pulse=1 after edge N+1; det_count=1; err_count=0; err_code=00.
REQ-031 Feed a real 10010010 serial stream through both detectors, with the Mealy output on mealy_in and the Moore output on moore_in -> det_count=2, err_flag=0, and two single-cycle match_pulses three cycles apart.
REQ-032 mealy_in=1 for one cycle, then moore_in=0 -> err_count=1, err_flag=1, err_code=01; then moore_in=1 alone -> err_count=2, err_code stays 01.
REQ-033 CW=8: drive 300 correctly paired events -> det_count saturates at 255; assert clr for one cycle -> all counters and flags return to 0.
REQ-034 mealy_in=1, then en=0 in the next cycle together with moore_in=1 -> no count change, match_pulse=0, FSM in IDLE; re-enable with moore_in=1 -> orphan-Moore error, err_code=10.
REQ-035 mealy_in=1 at cycle N and rst=1 at cycle N+1 -> all outputs 0 after edge N+1, and no error is counted at cycle N+2.

Source files
------------

// File: rtl/seq_event_monitor.sv
// Pairs Mealy and Moore 10010-detector outputs, counting matched detections and pairing errors.
// The Moore detector must fire exactly one cycle after the Mealy detector for a detection to count.
module seq_event_monitor #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          mealy_in,
  input  logic          moore_in,
  output logic          match_pulse,
  output logic [CW-1:0] det_count,
  output logic [CW-1:0] err_count,
  output logic          err_flag,
  output logic [1:0]    err_code
);

  typedef enum logic {StIdle, StPend} state_e;

  localparam logic [1:0] CodeMissedMoore = 2'b01;
  localparam logic [1:0] CodeOrphanMoore = 2'b10;

  state_e        r_state;
  state_e        w_state_d;
  logic          r_match_pulse;
  logic [CW-1:0] r_det_count;
  logic [CW-1:0] r_err_count;
  logic          r_err_flag;
  logic [1:0]    r_err_code;

  logic          w_pulse_d;
  logic          w_det_inc;
  logic          w_err;
  logic [1:0]    w_err_cause;

  always_comb begin
    w_state_d   = r_state;
    w_pulse_d   = 1'b0;
    w_det_inc   = 1'b0;
    w_err       = 1'b0;
    w_err_cause = 2'b00;
    if (!en) begin
      // Disabling drops any pending Mealy event without flagging it.
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (moore_in) begin
            w_err       = 1'b1;
            w_err_cause = CodeOrphanMoore;
          end
        end
        StPend: begin
          if (moore_in) begin
            w_det_inc = 1'b1;
            w_pulse_d = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_err_cause = CodeMissedMoore;
          end
        end
        default: ;
      endcase
      w_state_d = mealy_in ? StPend : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state       <= StIdle;
      r_match_pulse <= 1'b0;
      r_det_count   <= '0;
      r_err_count   <= '0;
      r_err_flag    <= 1'b0;
      r_err_code    <= 2'b00;
    end else begin
      r_state       <= w_state_d;
      r_match_pulse <= w_pulse_d;
      if (w_det_inc && (r_det_count != '1)) begin
        r_det_count <= r_det_count + 1'b1;
      end
      if (w_err) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + 1'b1;
        end
        r_err_flag <= 1'b1;
        // Only the first error since reset/clear is recorded.
        if (!r_err_flag) begin
          r_err_code <= w_err_cause;
        end
      end
    end
  end

  assign match_pulse = r_match_pulse;
  assign det_count   = r_det_count;
  assign err_count   = r_err_count;
  assign err_flag    = r_err_flag;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_seq_event_monitor.sv
// Scoreboard bench for seq_event_monitor: a behavioural model pushes expected outputs per driven
// cycle; they are popped and compared one time unit after the following rising edge.
module tb_seq_event_monitor;

  localparam int unsigned CW  = 8;
  localparam int unsigned Max = (1 << CW) - 1;

  typedef struct packed {
    logic          pulse;
    logic [CW-1:0] det;
    logic [CW-1:0] err;
    logic          flag;
    logic [1:0]    code;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          en;
  logic          clr;
  logic          mealy_in;
  logic          moore_in;
  logic          match_pulse;
  logic [CW-1:0] det_count;
  logic [CW-1:0] err_count;
  logic          err_flag;
  logic [1:0]    err_code;

  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  // Reference model state
  logic          m_pend;
  logic          m_pulse;
  int unsigned   m_det;
  int unsigned   m_err;
  logic          m_flag;
  logic [1:0]    m_code;

  seq_event_monitor #(.CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .mealy_in   (mealy_in),
    .moore_in   (moore_in),
    .match_pulse(match_pulse),
    .det_count  (det_count),
    .err_count  (err_count),
    .err_flag   (err_flag),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic i_rst, input logic i_en, input logic i_clr,
                       input logic i_mealy, input logic i_moore);
    logic       e;
    logic [1:0] c;
    e = 1'b0;
    c = 2'b00;
    if (i_rst || i_clr) begin
      m_pend = 1'b0; m_pulse = 1'b0; m_det = 0; m_err = 0; m_flag = 1'b0; m_code = 2'b00;
    end else if (!i_en) begin
      m_pend  = 1'b0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (m_pend && i_moore) begin
        m_pulse = 1'b1;
        if (m_det < Max) m_det++;
      end else if (m_pend) begin
        e = 1'b1; c = 2'b01;
      end else if (i_moore) begin
        e = 1'b1; c = 2'b10;
      end
      m_pend = i_mealy;
      if (e) begin
        if (m_err < Max) m_err++;
        if (!m_flag) m_code = c;
        m_flag = 1'b1;
      end
    end
  endtask

  task automatic step(input logic i_rst, input logic i_en, input logic i_clr,
                      input logic i_mealy, input logic i_moore);
    exp_t e;
    @(negedge clk);
    rst = i_rst; en = i_en; clr = i_clr; mealy_in = i_mealy; moore_in = i_moore;
    model(i_rst, i_en, i_clr, i_mealy, i_moore);
    exp_q.push_back({m_pulse, m_det[CW-1:0], m_err[CW-1:0], m_flag, m_code});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("match_pulse", {31'b0, match_pulse}, {31'b0, e.pulse});
      check_eq("det_count", {24'b0, det_count}, {24'b0, e.det});
      check_eq("err_count", {24'b0, err_count}, {24'b0, e.err});
      check_eq("err_flag", {31'b0, err_flag}, {31'b0, e.flag});
      check_eq("err_code", {30'b0, err_code}, {30'b0, e.code});
    end
  endtask

  initial begin
    logic [7:0] stream;
    logic [3:0] hist;
    logic       bit_v;
    logic       mealy_v;
    logic       moore_v;
    int         pulses;
    int         first_pulse;
    int         last_pulse;

    n_tests = 0; n_fail = 0;
    m_pend = 1'b0; m_pulse = 1'b0; m_det = 0; m_err = 0; m_flag = 1'b0; m_code = 2'b00;
    rst = 1'b1; en = 1'b0; clr = 1'b0; mealy_in = 1'b0; moore_in = 1'b0;

    // Reset with detector inputs active: they must be ignored
    step(1, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    check_eq("reset_det", {24'b0, det_count}, 32'd0);
    check_eq("reset_code", {30'b0, err_code}, 32'd0);

    // Single paired detection
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1);
    check_eq("pair_pulse", {31'b0, match_pulse}, 32'd1);
    check_eq("pair_det", {24'b0, det_count}, 32'd1);
    step(0, 1, 0, 0, 0);
    check_eq("pair_pulse_gone", {31'b0, match_pulse}, 32'd0);

    // Real 10010010 stream through Mealy/Moore detector models
    step(0, 1, 1, 0, 0);
    stream = 8'b10010010;
    hist = 4'b0000; moore_v = 1'b0; pulses = 0; first_pulse = -1; last_pulse = -1;
    for (int i = 0; i < 11; i++) begin
      bit_v   = (i < 8) ? stream[7-i] : 1'b0;
      mealy_v = (hist == 4'b1001) && !bit_v;
      step(0, 1, 0, mealy_v, moore_v);
      if (match_pulse) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        last_pulse = i;
      end
      moore_v = mealy_v;
      hist    = {hist[2:0], bit_v};
    end
    check_eq("stream_det", {24'b0, det_count}, 32'd2);
    check_eq("stream_flag", {31'b0, err_flag}, 32'd0);
    check_eq("stream_pulses", pulses, 32'd2);
    check_eq("stream_spacing", last_pulse - first_pulse, 32'd3);

    // Missed Moore then orphan Moore
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    check_eq("missed_err", {24'b0, err_count}, 32'd1);
    check_eq("missed_code", {30'b0, err_code}, 32'd1);
    step(0, 1, 0, 0, 1);
    check_eq("orphan_err", {24'b0, err_count}, 32'd2);
    check_eq("code_sticky", {30'b0, err_code}, 32'd1);

    // Saturation over 300 pairs, then clear
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 0, 1);
    end
    check_eq("sat_det", {24'b0, det_count}, 32'd255);
    check_eq("sat_err", {24'b0, err_count}, 32'd0);
    step(0, 1, 1, 1, 1);
    check_eq("clr_det", {24'b0, det_count}, 32'd0);
    check_eq("clr_pulse", {31'b0, match_pulse}, 32'd0);

    // Disable drops the pending event; re-enable with Moore is an orphan
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    check_eq("dis_pulse", {31'b0, match_pulse}, 32'd0);
    check_eq("dis_det", {24'b0, det_count}, 32'd0);
    step(0, 1, 0, 0, 1);
    check_eq("reen_code", {30'b0, err_code}, 32'd2);
    check_eq("reen_err", {24'b0, err_count}, 32'd1);

    // Reset while pending discards the event
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check_eq("rst_pend_err", {24'b0, err_count}, 32'd0);
    check_eq("rst_pend_flag", {31'b0, err_flag}, 32'd0);

    // Random traffic, mostly well-formed
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
